// File: rtl/program_loader.sv
// Byte-stream loader for the instruction memory: assembles big-endian words,
// writes them out, and owns pipeline enable/reset plus the command acknowledge.
module program_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              pipe_enable,
  output logic              pipe_rst,
  output logic              busy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << ADDR_W;
  localparam logic [1:0] LAST_BYTE = 2'(DATA_W / 8 - 1);

  localparam logic [7:0] C_LOAD = 8'h4C;
  localparam logic [7:0] C_RUN  = 8'h52;
  localparam logic [7:0] C_STOP = 8'h53;
  localparam logic [7:0] C_STEP = 8'h50;
  localparam logic [7:0] C_OK   = 8'h4B;
  localparam logic [7:0] C_ERR  = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_COUNT, S_GET_BYTE, S_WRITE, S_RUN, S_STEP, S_ACK
  } state_t;

  state_t              r_state;
  state_t              r_ret;
  logic [DATA_W-9:0]   r_sh;
  logic [1:0]          r_bcnt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_drop;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_en;
  logic                r_prst;
  logic                r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ret      <= S_IDLE;
      r_sh       <= '0;
      r_bcnt     <= '0;
      r_cnt      <= '0;
      r_drop     <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_en       <= 1'b0;
      r_prst     <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN: begin
          if (rx_valid) begin
            r_busy <= 1'b1;
            case (rx_data)
              C_LOAD: begin
                r_en    <= 1'b0;
                r_prst  <= 1'b1;
                r_drop  <= 1'b0;
                r_state <= S_GET_COUNT;
              end
              C_RUN: begin
                r_en       <= 1'b1;
                r_prst     <= 1'b0;
                r_tx_data  <= C_RUN;
                r_tx_valid <= 1'b1;
                r_ret      <= S_RUN;
                r_state    <= S_ACK;
              end
              C_STOP: begin
                r_en       <= 1'b0;
                r_tx_data  <= C_STOP;
                r_tx_valid <= 1'b1;
                r_ret      <= S_IDLE;
                r_state    <= S_ACK;
              end
              C_STEP: begin
                r_en       <= 1'b1;
                r_prst     <= 1'b0;
                r_tx_data  <= C_STEP;
                r_tx_valid <= 1'b1;
                r_ret      <= S_IDLE;
                r_state    <= S_STEP;
              end
              default: begin
                // Unknown byte: acknowledge with an error, resume where we were.
                r_tx_data  <= C_ERR;
                r_tx_valid <= 1'b1;
                r_ret      <= r_state;
                r_state    <= S_ACK;
              end
            endcase
          end
        end
        S_GET_COUNT: begin
          if (rx_valid) begin
            r_cnt   <= (rx_data == 8'd0) ? CNT_FULL : CNT_W'(rx_data);
            r_addr  <= '0;
            r_bcnt  <= '0;
            r_state <= S_GET_BYTE;
          end
        end
        S_GET_BYTE: begin
          if (rx_valid) begin
            r_sh   <= {r_sh[DATA_W-17:0], rx_data};
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == LAST_BYTE) begin
              r_wdata <= {r_sh, rx_data};
              r_we    <= 1'b1;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (rx_valid) r_drop <= 1'b1;
          r_addr <= r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            // A byte lost anywhere in the load turns the final OK into an error.
            r_tx_data  <= (r_drop || rx_valid) ? C_ERR : C_OK;
            r_tx_valid <= 1'b1;
            r_prst     <= 1'b0;
            r_ret      <= S_IDLE;
            r_state    <= S_ACK;
          end else begin
            r_state <= S_GET_BYTE;
          end
        end
        S_STEP: begin
          r_en <= 1'b0;
          if (rx_valid) r_drop <= 1'b1;
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (rx_valid) r_drop <= 1'b1;
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= r_ret;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign pipe_enable = r_en;
  assign pipe_rst    = r_prst;
  assign busy        = r_busy;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: transaction-level model of loads and commands,
// monitors collecting writes/acks, randomized data, pacing and tx_ready.
module tb_program_loader;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              pipe_enable;
  logic              pipe_rst;
  logic              busy;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pipe_enable(pipe_enable), .pipe_rst(pipe_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitors: everything sampled on the falling edge.
  int          we_cnt = 0;
  int          pe_cnt = 0;
  logic [6:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  ack_q[$];
  logic        pv = 1'b0;
  logic [7:0]  pd = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        we_cnt++;
        wa_q.push_back(imem_addr);
        wd_q.push_back(imem_wdata);
      end
      if (pipe_enable) pe_cnt++;
      if (tx_valid && tx_ready) ack_q.push_back(tx_data);
      if (pv && tx_valid) chk("tx_hold", {24'd0, tx_data}, {24'd0, pd});
      pv = tx_valid && !tx_ready;
      pd = tx_data;
    end else begin
      pv = 1'b0;
    end
  end

  // tx_ready: 0 = random, 1 = held low, 2 = held high
  int rdy_mode = 0;
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       tx_ready = 1'b0;
        2:       tx_ready = 1'b1;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference model of the pipeline control outputs
  logic        m_en, m_rst, m_run;
  logic [31:0] words [128];

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(1, 2)) @(posedge clk);
  endtask

  task automatic wait_ack(input logic [7:0] ea, input string tag);
    int n = 0;
    while (ack_q.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ack_q.size() == 0) chk({tag, "_timeout"}, ack_q.size(), 1);
    else chk(tag, {24'd0, ack_q.pop_front()}, {24'd0, ea});
    @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] b, input string tag);
    logic [7:0] ea;
    logic       en_now;
    logic       was_idle;
    int         pe0;
    was_idle = !m_run;
    case (b)
      8'h52:   begin ea = 8'h52; en_now = 1'b1; m_en = 1'b1; m_rst = 1'b0; m_run = 1'b1; end
      8'h53:   begin ea = 8'h53; en_now = 1'b0; m_en = 1'b0; m_run = 1'b0; end
      8'h50:   begin ea = 8'h50; en_now = 1'b1; m_en = 1'b0; m_rst = 1'b0; m_run = 1'b0; end
      default: begin ea = 8'h45; en_now = m_en; end
    endcase
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    pe0 = pe_cnt;
    @(negedge clk);
    rx_valid = 1'b0;
    chk({tag, "_txv"}, tx_valid, 1);
    chk({tag, "_txd"}, tx_data, ea);
    chk({tag, "_en1"}, pipe_enable, en_now);
    wait_ack(ea, {tag, "_ack"});
    chk({tag, "_en"}, pipe_enable, m_en);
    chk({tag, "_prst"}, pipe_rst, m_rst);
    chk({tag, "_busy"}, busy, 0);
    if (b == 8'h50 && was_idle) chk({tag, "_pulse"}, pe_cnt - pe0, 1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send(w[8*b +: 8]);
  endtask

  task automatic check_writes(input int n, input string tag);
    chk({tag, "_nwr"}, wa_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wa_q.size()) begin
        chk({tag, "_addr"}, {25'd0, wa_q[i]}, i % 128);
        chk({tag, "_data"}, wd_q[i], words[i]);
      end
    end
  endtask

  task automatic do_load(input int n, input string tag);
    wa_q.delete();
    wd_q.delete();
    send(8'h4C);
    send((n == 128) ? 8'h00 : 8'(n));
    chk({tag, "_prst_hold"}, pipe_rst, 1);
    chk({tag, "_en_off"}, pipe_enable, 0);
    chk({tag, "_busy"}, busy, 1);
    for (int i = 0; i < n; i++) send_word(words[i]);
    wait_ack(8'h4B, {tag, "_ack"});
    check_writes(n, tag);
    chk({tag, "_addr_end"}, {25'd0, imem_addr}, n % 128);
    chk({tag, "_prst"}, pipe_rst, 0);
    chk({tag, "_en"}, pipe_enable, 0);
    m_en = 1'b0; m_rst = 1'b0; m_run = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int         pe0;
    int         we0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_prst", pipe_rst, 1);
    chk("rst_en", pipe_enable, 0);
    chk("rst_we_cnt", we_cnt, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", {25'd0, imem_addr}, 0);
    m_en = 1'b0; m_rst = 1'b1; m_run = 1'b0;

    words[0] = 32'h20010005;
    words[1] = 32'h8C220004;
    do_load(2, "ld2");

    cmd(8'h52, "run");
    cmd(8'h53, "stop");

    // Single step with the transmitter stalled
    rdy_mode = 1;
    @(posedge clk); #1;
    rx_data  = 8'h50;
    rx_valid = 1'b1;
    @(posedge clk);
    pe0 = pe_cnt;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("p_txv", tx_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("p_hold_v", tx_valid, 1);
      chk("p_hold_d", tx_data, 8'h50);
    end
    chk("p_pulse", pe_cnt - pe0, 1);
    rdy_mode = 2;
    wait_ack(8'h50, "p_ack");
    rdy_mode = 0;
    chk("p_en", pipe_enable, 0);
    chk("p_busy", busy, 0);
    m_en = 1'b0; m_rst = 1'b0; m_run = 1'b0;

    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 3))
        0: b = 8'h52;
        1: b = 8'h53;
        2: b = 8'h50;
        default: begin
          b = 8'($urandom);
          while (b == 8'h4C || b == 8'h52 || b == 8'h53 || b == 8'h50) b = 8'($urandom);
        end
      endcase
      cmd(b, "rnd");
    end

    cmd(8'h52, "run2");
    cmd(8'h7A, "unk_run");

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 128; i++) words[i] = $urandom;
      do_load($urandom_range(1, 12), "rld");
    end

    // Byte arriving during the WRITE cycle is dropped and flags the load
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    wa_q.delete();
    wd_q.delete();
    send(8'h4C);
    send(8'h02);
    for (int i = 3; i >= 1; i--) send(words[0][8*i +: 8]);
    @(posedge clk); #1;
    rx_data  = words[0][7:0];
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_data  = 8'hAA;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    send_word(words[1]);
    wait_ack(8'h45, "drop_ack");
    check_writes(2, "drop");
    chk("drop_prst", pipe_rst, 0);

    for (int i = 0; i < 128; i++) words[i] = $urandom;
    do_load(128, "ld128");

    // Reset in the middle of a load
    for (int i = 0; i < 3; i++) words[i] = 32'hFFFF0000 | i;
    we0 = we_cnt;
    send(8'h4C);
    send(8'h03);
    send_word(words[0]);
    send(8'h12);
    send(8'h34);
    chk("rm_one_write", we_cnt - we0, 1);
    we0 = we_cnt;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rm_prst", pipe_rst, 1);
    chk("rm_en", pipe_enable, 0);
    chk("rm_we", imem_we, 0);
    chk("rm_addr", {25'd0, imem_addr}, 0);
    chk("rm_wdata", imem_wdata, 0);
    chk("rm_txv", tx_valid, 0);
    chk("rm_txd", tx_data, 0);
    chk("rm_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rm_no_more_writes", we_cnt, we0);
    chk("rm_busy_after", busy, 0);
    chk("rm_prst_after", pipe_rst, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
